// File: rtl/g15_pwrseq_pkg.sv
// Shared types for the G-15 power-up sequencer: state encoding seen on dbg_state,
// default durations and the registered output decode.
package g15_pwrseq_pkg;

  localparam int TW = 12;

  localparam int T_CLEAR_DEF   = 150;
  localparam int T_PRE_OP_DEF  = 30;
  localparam int T_OP_DEF      = 60;
  localparam int T_POST_OP_DEF = 30;
  localparam int T_SETTLE_DEF  = 120;
  localparam int T_ATS_DEF     = 30;
  localparam int T_NT_DEF      = 120;
  localparam int T_TAPE_TO_DEF = 4000;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_CLEAR   = 4'd1,
    ST_PRE_OP  = 4'd2,
    ST_OP      = 4'd3,
    ST_POST_OP = 4'd4,
    ST_SET1    = 4'd5,
    ST_ATS1    = 4'd6,
    ST_TAPE1   = 4'd7,
    ST_SET2    = 4'd8,
    ST_NT      = 4'd9,
    ST_SET3    = 4'd10,
    ST_ATS2    = 4'd11,
    ST_TAPE2   = 4'd12,
    ST_SET4    = 4'd13,
    ST_RUN     = 4'd14,
    ST_FAULT   = 4'd15
  } pwrseq_state_t;

  typedef struct packed {
    logic clear;
    logic op;
    logic no_op;
    logic ats;
    logic nt;
    logic go;
    logic busy;
    logic running;
  } pwr_out_t;

  localparam pwr_out_t OUT_RST = '{clear: 1'b0, op: 1'b0, no_op: 1'b1, ats: 1'b0,
                                   nt: 1'b0, go: 1'b0, busy: 1'b0, running: 1'b0};

  function automatic bit dur_ok(input int t);
    return (t >= 1) && (t <= 4095);
  endfunction

  function automatic pwr_out_t decode(input pwrseq_state_t s);
    pwr_out_t o;
    o = OUT_RST;
    case (s)
      ST_CLEAR:              o.clear = 1'b1;
      ST_PRE_OP, ST_POST_OP: o.no_op = 1'b0;
      ST_OP: begin
        o.no_op = 1'b0;
        o.op    = 1'b1;
      end
      ST_ATS1, ST_ATS2:      o.ats = 1'b1;
      ST_NT:                 o.nt = 1'b1;
      ST_RUN:                o.go = 1'b1;
      default: ;
    endcase
    o.busy    = !(s inside {ST_IDLE, ST_RUN, ST_FAULT});
    o.running = (s == ST_RUN);
    return o;
  endfunction

endpackage

// File: rtl/pwrseq_tick_timer.sv
// Per-state tick_ms counter; done fires on the tick that completes `limit` ticks.
module pwrseq_tick_timer
  import g15_pwrseq_pkg::*;
(
  input  logic          CLOCK,
  input  logic          clr_i,
  input  logic          en_i,
  input  logic          tick_i,
  input  logic [TW-1:0] limit_i,
  output logic          done_o
);

  localparam logic [TW-1:0] ONE = 1;

  logic [TW-1:0] cnt_q;

  assign done_o = en_i & tick_i & (cnt_q == (limit_i - ONE));

  always_ff @(posedge CLOCK) begin
    if (clr_i) cnt_q <= '0;
    else if (en_i && tick_i) cnt_q <= cnt_q + ONE;
  end

endmodule

// File: rtl/power_sequencer.sv
// G-15 power-up sequencer: clear, OP pulse, timing-track read-in, NT transfer, loader read-in, GO.
// Optional tape-wait timeout to FAULT is enabled by defining PWRSEQ_TAPE_TIMEOUT_EN.
module power_sequencer
  import g15_pwrseq_pkg::*;
#(
  parameter int T_CLEAR   = T_CLEAR_DEF,
  parameter int T_PRE_OP  = T_PRE_OP_DEF,
  parameter int T_OP      = T_OP_DEF,
  parameter int T_POST_OP = T_POST_OP_DEF,
  parameter int T_SETTLE  = T_SETTLE_DEF,
  parameter int T_ATS     = T_ATS_DEF,
  parameter int T_NT      = T_NT_DEF,
  parameter int T_TAPE_TO = T_TAPE_TO_DEF
) (
  input  logic       CLOCK,
  input  logic       rst,
  input  logic       tick_ms,
  input  logic       start,
  input  logic       abort,
  input  logic       WAIT_FOR_TAPE,
  output logic       PWR_CLEAR,
  output logic       PWR_NO_CLEAR,
  output logic       PWR_OP,
  output logic       PWR_NO_OP,
  output logic       PWR_ATS,
  output logic       PWR_NT,
  output logic       SW_GO,
  output logic       busy,
  output logic       running,
  output logic       fault,
  output logic [3:0] dbg_state
);

  if (!dur_ok(T_CLEAR) || !dur_ok(T_PRE_OP) || !dur_ok(T_OP) || !dur_ok(T_POST_OP) ||
      !dur_ok(T_SETTLE) || !dur_ok(T_ATS) || !dur_ok(T_NT) || !dur_ok(T_TAPE_TO)) begin : g_bad_dur
    $fatal(1, "power_sequencer: every duration parameter must be in 1..4095");
  end

  pwrseq_state_t state_q, state_d;
  pwr_out_t      out_q;
  logic          wft_q;
  logic          tape_fall;
  logic          tmr_en, tmr_done;
  logic [TW-1:0] limit;

  assign tape_fall = wft_q & ~WAIT_FOR_TAPE;

  always_comb begin
    limit  = 12'd1;
    tmr_en = 1'b1;
    case (state_q)
      ST_CLEAR:                            limit = 12'(T_CLEAR);
      ST_PRE_OP:                           limit = 12'(T_PRE_OP);
      ST_OP:                               limit = 12'(T_OP);
      ST_POST_OP:                          limit = 12'(T_POST_OP);
      ST_SET1, ST_SET2, ST_SET3, ST_SET4:  limit = 12'(T_SETTLE);
      ST_ATS1, ST_ATS2:                    limit = 12'(T_ATS);
      ST_NT:                               limit = 12'(T_NT);
`ifdef PWRSEQ_TAPE_TIMEOUT_EN
      ST_TAPE1, ST_TAPE2:                  limit = 12'(T_TAPE_TO);
`endif
      default:                             tmr_en = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (start) state_d = ST_CLEAR;
        ST_TAPE1, ST_TAPE2: begin
          // a tape fall beats a coincident timeout
          if (tape_fall) state_d = pwrseq_state_t'(state_q + 4'd1);
`ifdef PWRSEQ_TAPE_TIMEOUT_EN
          else if (tmr_done) state_d = ST_FAULT;
`endif
        end
        ST_RUN, ST_FAULT: ;
        default: if (tmr_done) state_d = pwrseq_state_t'(state_q + 4'd1);
      endcase
    end
  end

  pwrseq_tick_timer u_timer (
    .CLOCK   (CLOCK),
    .clr_i   (rst | (state_d != state_q)),
    .en_i    (tmr_en),
    .tick_i  (tick_ms),
    .limit_i (limit),
    .done_o  (tmr_done)
  );

  always_ff @(posedge CLOCK) begin
    if (rst) begin
      state_q <= ST_IDLE;
      out_q   <= OUT_RST;
    end else begin
      state_q <= state_d;
      out_q   <= decode(state_d);
    end
  end

  always_ff @(posedge CLOCK) wft_q <= WAIT_FOR_TAPE;

`ifdef PWRSEQ_TAPE_TIMEOUT_EN
  logic fault_q;
  always_ff @(posedge CLOCK) begin
    if (rst) fault_q <= 1'b0;
    else     fault_q <= (state_d == ST_FAULT);
  end
  assign fault = fault_q;
`else
  assign fault = 1'b0;
`endif

  assign PWR_CLEAR    = out_q.clear;
  assign PWR_NO_CLEAR = ~out_q.clear;
  assign PWR_OP       = out_q.op;
  assign PWR_NO_OP    = out_q.no_op;
  assign PWR_ATS      = out_q.ats;
  assign PWR_NT       = out_q.nt;
  assign SW_GO        = out_q.go;
  assign busy         = out_q.busy;
  assign running      = out_q.running;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_power_sequencer.sv
// Directed bench for power_sequencer with all durations 2 and tape timeout 5; a step-table
// model is compared against every output on every cycle, plus literal spot checks.
module tb_power_sequencer;

  localparam int T_STEP = 2;
  localparam int T_TO   = 5;

  logic CLOCK = 1'b0;
  logic rst = 1'b1, tick_ms = 1'b0, start = 1'b0, abort = 1'b0, WAIT_FOR_TAPE = 1'b0;
  logic PWR_CLEAR, PWR_NO_CLEAR, PWR_OP, PWR_NO_OP, PWR_ATS, PWR_NT, SW_GO;
  logic busy, running, fault;
  logic [3:0] dbg_state;

  int vectors = 0, miscompares = 0;
  int n_clr = 0, n_op = 0, n_ats = 0, n_nt = 0;
  bit chk_en = 1'b0;

  always #5 CLOCK = ~CLOCK;

  power_sequencer #(
    .T_CLEAR(T_STEP), .T_PRE_OP(T_STEP), .T_OP(T_STEP), .T_POST_OP(T_STEP),
    .T_SETTLE(T_STEP), .T_ATS(T_STEP), .T_NT(T_STEP), .T_TAPE_TO(T_TO)
  ) dut (
    .CLOCK(CLOCK), .rst(rst), .tick_ms(tick_ms), .start(start), .abort(abort),
    .WAIT_FOR_TAPE(WAIT_FOR_TAPE), .PWR_CLEAR(PWR_CLEAR), .PWR_NO_CLEAR(PWR_NO_CLEAR),
    .PWR_OP(PWR_OP), .PWR_NO_OP(PWR_NO_OP), .PWR_ATS(PWR_ATS), .PWR_NT(PWR_NT),
    .SW_GO(SW_GO), .busy(busy), .running(running), .fault(fault), .dbg_state(dbg_state)
  );

  // Model: step number in bring-up order (0 idle, 1..13 sequence, 14 run, 15 fault).
  int   m_step = 0, m_cnt = 0;
  logic m_wft = 1'b0;

  always @(posedge CLOCK) begin
    int s, c;
    logic fall;
    s = m_step;
    c = m_cnt;
    fall = m_wft && !WAIT_FOR_TAPE;
    if (rst || abort) begin
      s = 0; c = 0;
    end else if (s == 0) begin
      if (start) begin s = 1; c = 0; end
    end else if (s == 7 || s == 12) begin
      if (fall) begin s = s + 1; c = 0; end
`ifdef PWRSEQ_TAPE_TIMEOUT_EN
      else if (tick_ms) begin
        if (c + 1 == T_TO) begin s = 15; c = 0; end
        else c = c + 1;
      end
`endif
    end else if (s < 14 && tick_ms) begin
      if (c + 1 == T_STEP) begin s = s + 1; c = 0; end
      else c = c + 1;
    end
    m_step <= s;
    m_cnt  <= c;
    m_wft  <= WAIT_FOR_TAPE;
  end

  function automatic logic [13:0] exp_vec(input int s);
    logic [3:0] d;
    d = s[3:0];
    return {s == 1, s != 1, s == 3, !(s >= 2 && s <= 4), s == 6 || s == 11, s == 9,
            s == 14, s >= 1 && s <= 13, s == 14, s == 15, d};
  endfunction

  wire [13:0] dut_vec = {PWR_CLEAR, PWR_NO_CLEAR, PWR_OP, PWR_NO_OP, PWR_ATS, PWR_NT,
                         SW_GO, busy, running, fault, dbg_state};

  always @(negedge CLOCK) begin
    if (chk_en) begin
      vectors++;
      if (dut_vec !== exp_vec(m_step)) begin
        miscompares++;
        $display("FAIL cycle t=%0t step=%0d got=%b exp=%b", $time, m_step, dut_vec, exp_vec(m_step));
      end
      if (tick_ms) begin
        if (PWR_CLEAR) n_clr++;
        if (PWR_OP)    n_op++;
        if (PWR_ATS)   n_ats++;
        if (PWR_NT)    n_nt++;
      end
    end
  end

  initial begin
    int d;
    d = 0;
    forever begin
      @(posedge CLOCK);
      #1;
      tick_ms = (d == 3);
      d = (d + 1) % 4;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [15:0] got, input logic [15:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLOCK);
    #2;
  endtask

  task automatic run_to(input int s, input int budget);
    int n;
    n = 0;
    while (m_step != s && n < budget) begin cyc(); n++; end
    if (m_step != s) begin
      vectors++;
      miscompares++;
      $display("FAIL timeout waiting for step %0d (at %0d)", s, m_step);
    end
  endtask

  task automatic wait_ticks(input int n);
    int k;
    k = 0;
    while (k < n) begin cyc(); if (tick_ms) k++; end
  endtask

  task automatic pulse_start();
    start = 1'b1; cyc(); start = 1'b0;
  endtask

  task automatic run_full();
    pulse_start();
    run_to(6, 200);
    WAIT_FOR_TAPE = 1'b1;
    run_to(7, 100);
    wait_ticks(3);
    WAIT_FOR_TAPE = 1'b0;
    run_to(11, 300);
    WAIT_FOR_TAPE = 1'b1;
    run_to(12, 100);
    wait_ticks(3);
    WAIT_FOR_TAPE = 1'b0;
    run_to(14, 200);
  endtask

  task automatic clr_counts();
    n_clr = 0; n_op = 0; n_ats = 0; n_nt = 0;
  endtask

  initial begin
    @(posedge CLOCK);
    #1 chk_en = 1'b1;
    cyc();
    rst = 1'b0;
    cyc();
    check("rst_dbg", 16'(dbg_state), 16'd0);
    check("rst_no_clear", 16'(PWR_NO_CLEAR), 16'd1);
    check("rst_no_op", 16'(PWR_NO_OP), 16'd1);
    check("rst_busy", 16'(busy), 16'd0);

    // full sequence with pulse widths counted in ticks
    clr_counts();
    run_full();
    check("t1_clear_ticks", 16'(n_clr), 16'd2);
    check("t1_op_ticks", 16'(n_op), 16'd2);
    check("t1_ats_ticks", 16'(n_ats), 16'd4);
    check("t1_nt_ticks", 16'(n_nt), 16'd2);
    check("t1_go", 16'(SW_GO), 16'd1);
    check("t1_running", 16'(running), 16'd1);

    // tape fall during ATS1 must be ignored
    abort = 1'b1; cyc(); abort = 1'b0;
    pulse_start();
    run_to(6, 200);
    WAIT_FOR_TAPE = 1'b1; cyc(); cyc();
    WAIT_FOR_TAPE = 1'b0;
    check("t2_in_ats1", 16'(dbg_state), 16'd6);
    run_to(7, 100);
    wait_ticks(3);
    check("t2_held_tape1", 16'(dbg_state), 16'd7);
    WAIT_FOR_TAPE = 1'b1; cyc();
    WAIT_FOR_TAPE = 1'b0; cyc();
    check("t2_to_set2", 16'(dbg_state), 16'd8);

    // abort in NT together with a tick
    run_to(9, 100);
    while (!tick_ms) cyc();
    check("t3_in_nt", 16'(dbg_state), 16'd9);
    abort = 1'b1; cyc(); abort = 1'b0;
    check("t3_dbg", 16'(dbg_state), 16'd0);
    check("t3_nt", 16'(PWR_NT), 16'd0);
    check("t3_no_op", 16'(PWR_NO_OP), 16'd1);
    check("t3_busy", 16'(busy), 16'd0);

    // reset in OP, then a complete restart
    pulse_start();
    run_to(3, 100);
    rst = 1'b1; cyc(); rst = 1'b0;
    check("t4_op", 16'(PWR_OP), 16'd0);
    check("t4_no_op", 16'(PWR_NO_OP), 16'd1);
    check("t4_dbg", 16'(dbg_state), 16'd0);
    clr_counts();
    run_full();
    check("t4_clear_ticks", 16'(n_clr), 16'd2);
    check("t4_running", 16'(running), 16'd1);

    // start held in RUN does nothing
    start = 1'b1;
    repeat (20) cyc();
    start = 1'b0;
    check("t6_go", 16'(SW_GO), 16'd1);
    check("t6_dbg", 16'(dbg_state), 16'd14);

    // tape timeout behaviour
    abort = 1'b1; cyc(); abort = 1'b0;
    pulse_start();
    run_to(7, 200);
`ifdef PWRSEQ_TAPE_TIMEOUT_EN
    run_to(15, T_TO * 4 + 8);
    check("t5_fault", 16'(fault), 16'd1);
    check("t5_dbg_fault", 16'(dbg_state), 16'd15);
    abort = 1'b1; cyc(); abort = 1'b0;
    check("t5_fault_clr", 16'(fault), 16'd0);
    pulse_start();
    run_to(6, 200);
    WAIT_FOR_TAPE = 1'b1;
    run_to(7, 100);
    begin
      int n;
      n = 0;
      while (!(m_cnt == T_TO - 1 && tick_ms) && n < 100) begin cyc(); n++; end
    end
    WAIT_FOR_TAPE = 1'b0; cyc();
    check("t5_fall_wins", 16'(dbg_state), 16'd8);
    check("t5_no_fault", 16'(fault), 16'd0);
`else
    wait_ticks(8);
    check("t5_no_fault", 16'(fault), 16'd0);
    check("t5_waits", 16'(dbg_state), 16'd7);
    WAIT_FOR_TAPE = 1'b1; cyc();
    WAIT_FOR_TAPE = 1'b0; cyc();
    check("t5_to_set2", 16'(dbg_state), 16'd8);
`endif
    abort = 1'b1; cyc(); abort = 1'b0;
    cyc();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
